xlr8_d_mem_dp: RTL and testbench

XLR8_D_MEM_DP -- requirements
Module: xlr8_d_mem_dp

---
 rtl/xlr8_d_mem_dp.sv | 166 ++++++++++++++++
 tb/tb_xlr8_d_mem_dp.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/xlr8_d_mem_dp.sv
// rtl/xlr8_d_mem_dp.sv - Dual-port (CPU/DMA) data memory on one physical RAM with clear engine and anti-starvation arbiter.
// Optional parity protection enabled by defining XLR8_DMEM_PARITY_EN.
module xlr8_d_mem_dp #(
    parameter int DM_SIZE    = 1,
    parameter int DW         = 8,
    parameter int STARVE_MAX = 4
) (
    input  logic          cp2,
    input  logic          rst,
    input  logic          a_ce,
    input  logic          a_we,
    input  logic [15:0]   a_addr,
    input  logic [DW-1:0] a_din,
    output logic [DW-1:0] a_dout,
    output logic          a_wait,
    input  logic          b_req,
    input  logic          b_we,
    input  logic [15:0]   b_addr,
    input  logic [DW-1:0] b_din,
    output logic [DW-1:0] b_dout,
    output logic          b_gnt,
    output logic          b_rvalid,
    output logic          init_busy,
    output logic          par_err,
    input  logic          par_inj
);

    localparam int AW    = 10 + $clog2(DM_SIZE);
    localparam int DEPTH = 1 << AW;
`ifdef XLR8_DMEM_PARITY_EN
    localparam int RW = DW + 1;
`else
    localparam int RW = DW;
`endif

    typedef enum logic {S_CLEAR, S_RUN} state_t;

    state_t        state_q, state_d;
    logic [AW-1:0] clr_q, clr_d;
    logic [3:0]    starve_q, starve_d;
    logic [DW-1:0] a_dout_q, b_dout_q;
    logic          b_rvalid_q;
    logic          par_err_q;

    logic [RW-1:0] mem [DEPTH];

    logic          run;
    logic          a_sel, b_sel;
    logic          a_rd, b_rd;
    logic          ram_we;
    logic [AW-1:0] ram_addr;
    logic [DW-1:0] ram_wdata;
    logic          ram_wpar;
    logic [RW-1:0] ram_word;
    logic [RW-1:0] rd_word;
    logic          par_bad;
    logic          unused_ok;

    // FSM next state, arbitration and RAM port steering
    always_comb begin
        state_d   = state_q;
        clr_d     = clr_q;
        starve_d  = 4'd0;
        run       = (state_q == S_RUN) && !rst;
        a_wait    = 1'b1;
        a_sel     = 1'b0;
        b_sel     = 1'b0;
        ram_we    = 1'b0;
        ram_addr  = clr_q;
        ram_wdata = '0;
        ram_wpar  = 1'b0;
        case (state_q)
            S_CLEAR: begin
                if (!rst) begin
                    ram_we = 1'b1;
                    clr_d  = clr_q + 1'b1;
                    if (clr_q == {AW{1'b1}}) begin
                        state_d = S_RUN;
                    end
                end
            end
            S_RUN: begin
                if (run) begin
                    a_wait = (starve_q == 4'(STARVE_MAX));
                    a_sel  = a_ce && !a_wait;
                    b_sel  = !a_sel && b_req;
                    if (b_req && !b_sel) begin
                        starve_d = starve_q + 4'd1;
                    end
                end
                if (a_sel) begin
                    ram_addr  = a_addr[AW-1:0];
                    ram_we    = a_we;
                    ram_wdata = a_din;
                    ram_wpar  = (^a_din) ^ par_inj;
                end else if (b_sel) begin
                    ram_addr  = b_addr[AW-1:0];
                    ram_we    = b_we;
                    ram_wdata = b_din;
                    ram_wpar  = (^b_din) ^ par_inj;
                end
            end
            default: state_d = S_CLEAR;
        endcase
    end

    assign a_rd      = a_sel && !a_we;
    assign b_rd      = b_sel && !b_we;
    assign b_gnt     = b_sel;
    assign init_busy = !run;

`ifdef XLR8_DMEM_PARITY_EN
    assign ram_word  = {ram_wpar, ram_wdata};
    assign par_bad   = ^rd_word;
    assign unused_ok = ^{a_addr, b_addr};
`else
    assign ram_word  = ram_wdata;
    assign par_bad   = 1'b0;
    assign unused_ok = ^{a_addr, b_addr, par_inj, ram_wpar};
`endif

    always_ff @(posedge cp2) begin
        if (rst) begin
            state_q  <= S_CLEAR;
            clr_q    <= '0;
            starve_q <= 4'd0;
        end else begin
            state_q  <= state_d;
            clr_q    <= clr_d;
            starve_q <= starve_d;
        end
    end

    // RAM array carries no reset; the clear engine initialises it
    always_ff @(posedge cp2) begin
        if (ram_we) begin
            mem[ram_addr] <= ram_word;
        end
    end

    assign rd_word = mem[ram_addr];

    always_ff @(posedge cp2) begin
        if (rst) begin
            a_dout_q   <= '0;
            b_dout_q   <= '0;
            b_rvalid_q <= 1'b0;
            par_err_q  <= 1'b0;
        end else begin
            b_rvalid_q <= b_rd;
            if (a_rd) begin
                a_dout_q <= rd_word[DW-1:0];
            end
            if (b_rd) begin
                b_dout_q <= rd_word[DW-1:0];
            end
            par_err_q <= par_err_q | ((a_rd | b_rd) & par_bad);
        end
    end

    assign a_dout   = a_dout_q;
    assign b_dout   = b_dout_q;
    assign b_rvalid = b_rvalid_q;
    assign par_err  = par_err_q;

endmodule

// File: tb/tb_xlr8_d_mem_dp.sv
// tb/tb_xlr8_d_mem_dp.sv - Directed self-checking bench for xlr8_d_mem_dp with read-data scoreboard.
module tb_xlr8_d_mem_dp;

    localparam int DW = 8;

    logic          cp2 = 1'b0;
    logic          rst;
    logic          a_ce, a_we;
    logic [15:0]   a_addr;
    logic [DW-1:0] a_din, a_dout;
    logic          a_wait;
    logic          b_req, b_we;
    logic [15:0]   b_addr;
    logic [DW-1:0] b_din, b_dout;
    logic          b_gnt, b_rvalid, init_busy, par_err, par_inj;

    int errors = 0;
    int checks = 0;
    logic [DW-1:0] aq[$];
    logic [DW-1:0] bq[$];
    logic          exp_perr;

    xlr8_d_mem_dp #(.DM_SIZE(1), .DW(DW), .STARVE_MAX(4)) dut (
        .cp2(cp2), .rst(rst),
        .a_ce(a_ce), .a_we(a_we), .a_addr(a_addr), .a_din(a_din), .a_dout(a_dout), .a_wait(a_wait),
        .b_req(b_req), .b_we(b_we), .b_addr(b_addr), .b_din(b_din), .b_dout(b_dout),
        .b_gnt(b_gnt), .b_rvalid(b_rvalid), .init_busy(init_busy),
        .par_err(par_err), .par_inj(par_inj)
    );

    always #5 cp2 = ~cp2;

    task automatic step();
        @(posedge cp2);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic idle();
        a_ce = 0; a_we = 0; b_req = 0; b_we = 0; par_inj = 0;
    endtask

    task automatic wait_clear(output int n);
        n = 0;
        while (init_busy && n < 2000) begin
            n++;
            step();
        end
    endtask

    task automatic a_write(input logic [15:0] ad, input logic [DW-1:0] d);
        a_ce = 1; a_we = 1; a_addr = ad; a_din = d;
        step();
        idle();
    endtask

    task automatic a_read(input string tag, input logic [15:0] ad, input logic [DW-1:0] exp);
        logic [DW-1:0] e;
        a_ce = 1; a_we = 0; a_addr = ad;
        aq.push_back(exp);
        step();
        idle();
        e = aq.pop_front();
        chk(tag, a_dout, e);
    endtask

    initial begin
        int n;
        logic [DW-1:0] e;
        idle();
        rst = 1; a_addr = 0; a_din = 0; b_addr = 0; b_din = 0;
        #1;
        chk("rst_init_busy", init_busy, 1);
        chk("rst_a_wait", a_wait, 1);
        b_req = 1; #1;
        chk("rst_b_gnt", b_gnt, 0);
        b_req = 0;
        step();
        chk("rst_a_dout", a_dout, 0);
        chk("rst_b_dout", b_dout, 0);
        chk("rst_b_rvalid", b_rvalid, 0);
        chk("rst_par_err", par_err, 0);
        rst = 0;

        wait_clear(n);
        chk("clear_cycles", n, 1024);
        chk("run_a_wait", a_wait, 0);

        for (int i = 0; i < 1024; i++) a_read("clear_zero", 16'(i), 8'h00);

        a_write(16'h0010, 8'hA5);
        chk("write_keeps_a_dout", a_dout, 8'h00);
        a_read("a_rd_0010", 16'h0010, 8'hA5);
        a_read("a_rd_alias_0410", 16'h0410, 8'hA5);

        b_req = 1; b_we = 1; b_addr = 16'h0020; b_din = 8'h3C; #1;
        chk("b_wr_gnt", b_gnt, 1);
        step();
        chk("b_wr_no_rvalid", b_rvalid, 0);
        b_we = 0; #1;
        chk("b_rd_gnt", b_gnt, 1);
        bq.push_back(8'h3C);
        step();
        b_req = 0;
        chk("b_rd_rvalid", b_rvalid, 1);
        e = bq.pop_front();
        chk("b_rd_data", b_dout, e);
        chk("b_rd_a_dout_kept", a_dout, 8'hA5);
        step();
        chk("b_rvalid_drop", b_rvalid, 0);
        chk("b_dout_hold", b_dout, 8'h3C);

        a_ce = 1; a_we = 0; a_addr = 16'h0010;
        b_req = 1; b_we = 0; b_addr = 16'h0020; #1;
        for (int k = 0; k < 4; k++) begin
            chk("starve_deny_gnt", b_gnt, 0);
            chk("starve_deny_wait", a_wait, 0);
            step();
            chk("starve_a_dout", a_dout, 8'hA5);
        end
        chk("starve_hit_wait", a_wait, 1);
        chk("starve_hit_gnt", b_gnt, 1);
        bq.push_back(8'h3C);
        step();
        chk("starve_rvalid", b_rvalid, 1);
        e = bq.pop_front();
        chk("starve_b_dout", b_dout, e);
        chk("starve_after_wait", a_wait, 0);
        chk("starve_after_gnt", b_gnt, 0);
        idle();
        step();

`ifdef XLR8_DMEM_PARITY_EN
        exp_perr = 1'b1;
`else
        exp_perr = 1'b0;
`endif
        chk("par_clean", par_err, 0);
        a_ce = 1; a_we = 1; a_addr = 16'h0030; a_din = 8'h5A; par_inj = 1;
        step();
        idle();
        chk("par_after_write", par_err, 0);
        a_read("par_rd_data", 16'h0030, 8'h5A);
        chk("par_err_set", par_err, exp_perr);
        step(); step();
        chk("par_err_sticky", par_err, exp_perr);
        a_read("par_rd_good", 16'h0010, 8'hA5);
        chk("par_err_sticky2", par_err, exp_perr);

        rst = 1; b_req = 1; b_we = 0; b_addr = 16'h0020; #1;
        chk("mid_rst_gnt", b_gnt, 0);
        chk("mid_rst_busy", init_busy, 1);
        chk("mid_rst_wait", a_wait, 1);
        step();
        rst = 0; idle();
        chk("mid_rst_rvalid", b_rvalid, 0);
        chk("mid_rst_a_dout", a_dout, 0);
        chk("mid_rst_b_dout", b_dout, 0);
        chk("mid_rst_par_err", par_err, 0);
        wait_clear(n);
        chk("mid_rst_clear_cycles", n, 1024);
        a_read("post_rst_0010", 16'h0010, 8'h00);
        a_read("post_rst_0020", 16'h0020, 8'h00);
        a_read("post_rst_0030", 16'h0030, 8'h00);
        chk("post_rst_par_err", par_err, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
